// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debouncer bank.
// Channel FSM state enum and counter-width helper.
package debounce_pkg;

  typedef enum logic {
    DB_IDLE,
    DB_TRAN
  } db_state_t;

  function automatic int cnt_width(input int count_max);
    return (count_max < 1) ? 1 : $clog2(count_max + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: IDLE/TRAN FSM, stable-tick counter, pulse regs.
// Ports: clk, rst, tick, a_s in; db_out, rise, fall, evt_d (next pulse) out.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   COUNT_MAX = 15,
  parameter logic INIT      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic a_s,
  output logic db_out,
  output logic rise,
  output logic fall,
  output logic evt_d
);

  localparam int CW = cnt_width(COUNT_MAX);
  localparam logic [CW-1:0] LAST = CW'(COUNT_MAX - 1);

  db_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic db_q, db_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      DB_IDLE: begin
        cnt_d = '0;
        if (a_s != db_q) state_d = DB_TRAN;
      end
      DB_TRAN: begin
        // agreement aborts on any clk, tick or not
        if (a_s == db_q) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == LAST) begin
            db_d    = ~db_q;
            rise_d  = ~db_q;
            fall_d  = db_q;
            state_d = DB_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      db_q    <= INIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign db_out = db_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign evt_d  = rise_d | fall_d;

endmodule

// File: rtl/debouncer_bank.sv
// N-channel debouncer with shared tick prescaler; optional 2-flop input
// sync when DEBOUNCE_SYNC_EN is defined. Ports: clk, rst, a -> db_out, rise, fall, changed.
module debouncer_bank
  import debounce_pkg::*;
#(
  parameter int                  CHANNELS  = 4,
  parameter int                  COUNT_MAX = 15,
  parameter int                  TICK_DIV  = 1,
  parameter logic [CHANNELS-1:0] INIT      = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] a,
  output logic [CHANNELS-1:0] db_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  logic                tick;
  logic [CHANNELS-1:0] a_s;
  logic [CHANNELS-1:0] evt_d;
  logic                changed_q, changed_d;

  generate
    if (TICK_DIV > 1) begin : g_pre
      localparam int PW = $clog2(TICK_DIV);
      localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
      logic [PW-1:0] pcnt_q, pcnt_d;

      always_comb begin
        pcnt_d = (pcnt_q == PLAST) ? '0 : pcnt_q + 1'b1;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) pcnt_q <= '0;
        else     pcnt_q <= pcnt_d;
      end

      assign tick = (pcnt_q == PLAST);
    end else begin : g_nopre
      assign tick = 1'b1;
    end
  endgenerate

`ifdef DEBOUNCE_SYNC_EN
  logic [CHANNELS-1:0] sync1_q, sync1_d;
  logic [CHANNELS-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = a;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= INIT;
      sync2_q <= INIT;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign a_s = sync2_q;
`else
  assign a_s = a;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .COUNT_MAX (COUNT_MAX),
      .INIT      (INIT[i])
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .a_s    (a_s[i]),
      .db_out (db_out[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .evt_d  (evt_d[i])
    );
  end

  always_comb begin
    changed_d = |evt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) changed_q <= 1'b0;
    else     changed_q <= changed_d;
  end

  assign changed = changed_q;

endmodule
